// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Optional op_sub member exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
  logic             op_sub;

  modport master (
    output din, din_valid, result_ready, op_sub,
    input  din_ready, result, cout, result_valid, busy, op_a, op_b
  );
  modport slave (
    input  din, din_valid, result_ready, op_sub,
    output din_ready, result, cout, result_valid, busy, op_a, op_b
  );
`else
  modport master (
    output din, din_valid, result_ready,
    input  din_ready, result, cout, result_valid, busy, op_a, op_b
  );
  modport slave (
    input  din, din_valid, result_ready,
    output din_ready, result, cout, result_valid, busy, op_a, op_b
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures A then B, adds one bit per clock, holds the sum.
// Define SERIAL_ADD_SUB_EN to add the op_sub input (A-B via inverted B and carry-in 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  serial_add_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GET_B = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-2:0] r_shSum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_sub;
  logic             w_bitSum;
  logic             w_carryNext;
  logic [WIDTH-1:0] w_sumWord;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub = bus.op_sub;
`else
  assign w_sub = 1'b0;
`endif

  // One full-adder slice; w_sumWord is the accumulated sum including this cycle's bit.
  assign w_bitSum    = r_shA[0] ^ r_shB[0] ^ r_carry;
  assign w_carryNext = (r_shA[0] & r_shB[0]) | (r_shA[0] & r_carry) | (r_shB[0] & r_carry);
  assign w_sumWord   = {w_bitSum, r_shSum};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_opA    <= '0;
      r_opB    <= '0;
      r_shA    <= '0;
      r_shB    <= '0;
      r_shSum  <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.din_valid) begin
            r_opA   <= bus.din;
            r_shA   <= bus.din;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          // Subtraction is A + ~B + 1; op_b keeps the uninverted operand for display.
          if (bus.din_valid) begin
            r_opB   <= bus.din;
            r_shB   <= w_sub ? ~bus.din : bus.din;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_carry <= w_carryNext;
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_shSum <= w_sumWord[WIDTH-1:1];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_result <= w_sumWord;
            r_cout   <= w_carryNext;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.result_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags are pure state decodes, so no input-to-output combinational path.
  assign bus.din_ready    = (r_state == S_IDLE) || (r_state == S_GET_B);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result       = r_result;
  assign bus.cout         = r_cout;
  assign bus.op_a         = r_opA;
  assign bus.op_b         = r_opB;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

  logic clock;
  logic reset;
  int   checkCount;
  int   errorCount;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendOperand(input logic [7:0] data);
    int waitCycles;
    waitCycles = 0;
    @(negedge clock);
    bus.din       = data;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    checkOutput("dinReadyWait", 32'(waitCycles < 50), 32'd1);
    @(posedge clock);
  endtask

  // Sends A then B, then measures edges from the B transfer edge (counted as 1) to result_valid.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int lat;
`ifdef SERIAL_ADD_SUB_EN
    bus.op_sub = 1'b0;
`endif
    sendOperand(a);
`ifdef SERIAL_ADD_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("[TB] op_sub ignored in add-only build");
`endif
    sendOperand(b);
    lat = 1;
    @(negedge clock);
    bus.din_valid = 1'b0;
    while (!bus.result_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    checkOutput("latency", 32'(lat), 32'd9);
  endtask

  task automatic checkResult(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] expRes, input logic expCout);
    checkOutput({tag, ".result"}, 32'(bus.result), 32'(expRes));
    checkOutput({tag, ".cout"}, 32'(bus.cout), 32'(expCout));
    checkOutput({tag, ".opA"}, 32'(bus.op_a), 32'(a));
    checkOutput({tag, ".opB"}, 32'(bus.op_b), 32'(b));
    checkOutput({tag, ".dinReady"}, 32'(bus.din_ready), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic completeHandshake(input string tag, input logic [7:0] expRes);
    bus.result_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.result_ready = 1'b0;
    checkOutput({tag, ".validDrop"}, 32'(bus.result_valid), 32'd0);
    checkOutput({tag, ".idleReady"}, 32'(bus.din_ready), 32'd1);
    checkOutput({tag, ".idleBusy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".resultHeld"}, 32'(bus.result), 32'(expRes));
  endtask

  initial begin
    logic [7:0] ops [4];
    logic [7:0] expSums [2];
    int aCycle [2];
    int idx;
    int nres;
    int cyc;
    logic willXfer;

    checkCount       = 0;
    errorCount       = 0;
    reset            = 1'b1;
    bus.din          = '0;
    bus.din_valid    = 1'b0;
    bus.result_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.op_sub       = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    checkOutput("rst.resultValid", 32'(bus.result_valid), 32'd0);
    checkOutput("rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("rst.dinReady", 32'(bus.din_ready), 32'd1);
    checkOutput("rst.result", 32'(bus.result), 32'd0);
    checkOutput("rst.cout", 32'(bus.cout), 32'd0);
    checkOutput("rst.opA", 32'(bus.op_a), 32'd0);
    checkOutput("rst.opB", 32'(bus.op_b), 32'd0);

    applyStimulus(8'h3C, 8'h05, 1'b0);
    checkResult("add3C05", 8'h3C, 8'h05, 8'h41, 1'b0);
    completeHandshake("add3C05", 8'h41);

    applyStimulus(8'hFF, 8'h01, 1'b0);
    checkResult("addFF01", 8'hFF, 8'h01, 8'h00, 1'b1);
    completeHandshake("addFF01", 8'h00);

    applyStimulus(8'h80, 8'h80, 1'b0);
    checkResult("add8080", 8'h80, 8'h80, 8'h00, 1'b1);
    completeHandshake("add8080", 8'h00);

    applyStimulus(8'h00, 8'h00, 1'b0);
    checkResult("add0000", 8'h00, 8'h00, 8'h00, 1'b0);
    completeHandshake("add0000", 8'h00);

    // Stall in DONE while the producer keeps offering toggling data.
    applyStimulus(8'h5A, 8'h21, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.din       = (i % 2 == 0) ? 8'hFF : 8'h00;
      bus.din_valid = 1'b1;
      checkOutput("hold.result", 32'(bus.result), 32'h7B);
      checkOutput("hold.valid", 32'(bus.result_valid), 32'd1);
      checkOutput("hold.dinReady", 32'(bus.din_ready), 32'd0);
      @(negedge clock);
    end
    checkOutput("hold.cout", 32'(bus.cout), 32'd0);
    checkOutput("hold.opA", 32'(bus.op_a), 32'h5A);
    checkOutput("hold.opB", 32'(bus.op_b), 32'h21);
    bus.din_valid = 1'b0;
    completeHandshake("hold", 8'h7B);

    // Reset lands on the 4th ADD edge.
    sendOperand(8'hAA);
    sendOperand(8'h55);
    @(negedge clock);
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midRst.busy", 32'(bus.busy), 32'd0);
    checkOutput("midRst.valid", 32'(bus.result_valid), 32'd0);
    checkOutput("midRst.result", 32'(bus.result), 32'd0);
    checkOutput("midRst.opA", 32'(bus.op_a), 32'd0);
    checkOutput("midRst.opB", 32'(bus.op_b), 32'd0);
    checkOutput("midRst.dinReady", 32'(bus.din_ready), 32'd1);

    applyStimulus(8'h12, 8'h34, 1'b0);
    checkResult("add1234", 8'h12, 8'h34, 8'h46, 1'b0);
    completeHandshake("add1234", 8'h46);

    // Back-to-back with ready held high; A transfers should be 11 cycles apart.
    ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h7F; ops[3] = 8'h01;
    expSums[0] = 8'h03; expSums[1] = 8'h80;
    aCycle[0] = 0; aCycle[1] = 0;
    idx = 0; nres = 0; cyc = 0;
    bus.result_ready = 1'b1;
    while (nres < 2 && cyc < 100) begin
      @(negedge clock);
      bus.din_valid = (idx < 4);
      if (idx < 4) bus.din = ops[idx];
      willXfer = bus.din_ready && bus.din_valid;
      if (bus.result_valid) begin
        checkOutput("b2b.result", 32'(bus.result), 32'(expSums[nres]));
        checkOutput("b2b.cout", 32'(bus.cout), 32'd0);
        nres++;
      end
      if (willXfer && (idx % 2 == 0)) aCycle[idx / 2] = cyc;
      if (willXfer) idx++;
      @(posedge clock);
      cyc++;
    end
    checkOutput("b2b.done", 32'(nres), 32'd2);
    checkOutput("b2b.period", 32'(aCycle[1] - aCycle[0]), 32'd11);
    @(negedge clock);
    bus.result_ready = 1'b0;
    bus.din_valid    = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b1);
    checkResult("sub1001", 8'h10, 8'h01, 8'h0F, 1'b1);
    completeHandshake("sub1001", 8'h0F);

    applyStimulus(8'h01, 8'h02, 1'b1);
    checkResult("sub0102", 8'h01, 8'h02, 8'hFF, 1'b0);
    completeHandshake("sub0102", 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
